// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 19-bit CPU.
// Fetches into ir, decodes the opcode and drives every datapath strobe.
module cpu_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_done,
    input  logic        alu_zero,
    output logic [18:0] ir,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_start,
    output logic [4:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        illegal_op,
    output logic        halted,
    output logic [2:0]  state
);

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_ART    = 5'd0;
    localparam logic [OPW-1:0] OP_LOG    = 5'd1;
    localparam logic [OPW-1:0] OP_CRY    = 5'd2;
    localparam logic [OPW-1:0] OP_IMM    = 5'd3;
    localparam logic [OPW-1:0] OP_LD     = 5'd4;
    localparam logic [OPW-1:0] OP_ST     = 5'd5;
    localparam logic [OPW-1:0] OP_JMP    = 5'd6;
    localparam logic [OPW-1:0] OP_BEQ    = 5'd7;
    localparam logic [OPW-1:0] OP_HLT    = 5'd31;
    localparam logic [OPW-1:0] ALU_IMMED = 5'd16;
    localparam logic [OPW-1:0] ALU_SUB   = 5'd1;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t         state_q;
    logic           prev_decode;
    logic [OPW-1:0] opcode;
    logic [OPW-1:0] funct;
    logic           is_rtype;
    logic           is_imm_grp;
    logic           is_ld;
    logic           is_st;
    logic           is_jmp;
    logic           is_beq;
    logic           is_hlt;
    logic           is_legal;
    logic [OPW-1:0] dec_alu_op;

    assign opcode = ir[18:14];
    assign funct  = ir[4:0];
    assign state  = state_q;

    // Opcode class decode from the instruction register.
    always_comb begin
        is_rtype   = (opcode == OP_ART) || (opcode == OP_LOG) || (opcode == OP_CRY);
        is_ld      = (opcode == OP_LD);
        is_st      = (opcode == OP_ST);
        is_imm_grp = (opcode == OP_IMM) || is_ld || is_st;
        is_jmp     = (opcode == OP_JMP);
        is_beq     = (opcode == OP_BEQ);
        is_hlt     = (opcode == OP_HLT);
        is_legal   = is_rtype || is_imm_grp || is_jmp || is_beq || is_hlt;
    end

    always_comb begin
        dec_alu_op = '0;
        if (is_rtype) begin
            dec_alu_op = funct;
        end else if (is_imm_grp) begin
            dec_alu_op = ALU_IMMED;
        end else if (is_beq) begin
            dec_alu_op = ALU_SUB;
        end
    end

    // Sequencer: state, instruction register and latched ALU op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            ir          <= '0;
            alu_op      <= '0;
            prev_decode <= 1'b0;
        end else begin
            // EXECUTE is only entered from DECODE, so this marks its first cycle
            prev_decode <= (state_q == S_DECODE);
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_rdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op <= dec_alu_op;
                    if (is_jmp || !is_legal) begin
                        state_q <= S_FETCH;
                    end else if (is_hlt) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (alu_done) begin
                        if (is_ld || is_st) begin
                            state_q <= S_MEM;
                        end else if (is_rtype || is_imm_grp) begin
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= is_ld ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Datapath strobes decoded from state, ir and handshake inputs; all low in reset.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_start    = 1'b0;
        alu_src_imm  = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 1'b0;
        illegal_op   = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    pc_en   = mem_ready;
                end
                S_DECODE: begin
                    pc_en      = is_jmp;
                    pc_sel     = is_jmp;
                    illegal_op = !is_legal;
                end
                S_EXECUTE: begin
                    alu_start   = prev_decode;
                    alu_src_imm = is_imm_grp;
                    pc_en       = alu_done && is_beq && alu_zero;
                    pc_sel      = alu_done && is_beq && alu_zero;
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_st;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = is_ld;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-cycle expected snapshots are queued
// as stimulus is applied and compared on the following falling edge.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        alu_done = 1'b0;
    logic        alu_zero = 1'b0;
    logic [18:0] ir;
    logic        mem_req, mem_we, mem_addr_sel, alu_start, alu_src_imm;
    logic [4:0]  alu_op;
    logic        reg_we, wb_sel, pc_en, pc_sel, illegal_op, halted;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    logic [37:0] exp_q[$];
    string       tag_q[$];

    localparam logic [10:0] REQ  = 11'h400;
    localparam logic [10:0] WE   = 11'h200;
    localparam logic [10:0] ASEL = 11'h100;
    localparam logic [10:0] AST  = 11'h080;
    localparam logic [10:0] SIMM = 11'h040;
    localparam logic [10:0] RWE  = 11'h020;
    localparam logic [10:0] WBS  = 11'h010;
    localparam logic [10:0] PCE  = 11'h008;
    localparam logic [10:0] PCS  = 11'h004;
    localparam logic [10:0] ILL  = 11'h002;
    localparam logic [10:0] HLTD = 11'h001;

    localparam logic [18:0] I_ART = {5'd0, 9'd0, 5'd9};
    localparam logic [18:0] I_LD  = {5'd4, 9'h0c3, 5'd3};
    localparam logic [18:0] I_BEQ = {5'd7, 9'h012, 5'd0};
    localparam logic [18:0] I_ST  = {5'd5, 9'h1a5, 5'd7};
    localparam logic [18:0] I_BAD = {5'd12, 14'h0};
    localparam logic [18:0] I_JMP = {5'd6, 14'h3};
    localparam logic [18:0] I_HLT = {5'd31, 14'h0};

    cpu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_done(alu_done), .alu_zero(alu_zero), .ir(ir), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_start(alu_start),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
        .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel),
        .illegal_op(illegal_op), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    logic [37:0] obs;
    assign obs = {state, ir, alu_op, mem_req, mem_we, mem_addr_sel, alu_start,
                  alu_src_imm, reg_we, wb_sel, pc_en, pc_sel, illegal_op, halted};

    // Scoreboard: pop one expected snapshot per cycle, mid-cycle.
    always @(negedge clk) begin
        logic [37:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s got=%h exp=%h", t, obs, e);
            end
        end
    end

    task automatic step(input logic r, input logic rdy, input logic done, input logic zero,
                        input logic [18:0] rd, input logic [2:0] st, input logic [18:0] eir,
                        input logic [4:0] eop, input logic [10:0] sb, input string tag);
        rst       = r;
        mem_ready = rdy;
        alu_done  = done;
        alu_zero  = zero;
        mem_rdata = rd;
        exp_q.push_back({st, eir, eop, sb});
        tag_q.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 1, 1, 0, I_ART, 3'd0, 19'd0, 5'd0, 11'd0, "rst0");
        step(1, 1, 1, 0, I_ART, 3'd0, 19'd0, 5'd0, 11'd0, "rst1");
        // ART funct 9, zero-wait memory and ALU
        step(0, 1, 1, 0, I_ART, 3'd0, 19'd0,  5'd0, REQ | PCE, "art_f");
        step(0, 1, 1, 0, I_LD,  3'd1, I_ART,  5'd0, 11'd0,     "art_d");
        step(0, 1, 1, 0, I_LD,  3'd2, I_ART,  5'd9, AST,       "art_e");
        step(0, 1, 1, 0, I_LD,  3'd4, I_ART,  5'd9, RWE,       "art_wb");
        // LD with 3 wait cycles in FETCH and MEM: 11 cycles
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, I_LD, 3'd0, I_ART, 5'd9, REQ, "ld_fw");
        step(0, 1, 1, 0, I_LD,  3'd0, I_ART, 5'd9,  REQ | PCE,  "ld_f");
        step(0, 0, 1, 0, I_BEQ, 3'd1, I_LD,  5'd9,  11'd0,      "ld_d");
        step(0, 0, 1, 0, I_BEQ, 3'd2, I_LD,  5'd16, AST | SIMM, "ld_e");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, I_BEQ, 3'd3, I_LD, 5'd16, REQ | ASEL, "ld_mw");
        step(0, 1, 1, 0, I_BEQ, 3'd3, I_LD,  5'd16, REQ | ASEL, "ld_m");
        step(0, 1, 1, 0, I_BEQ, 3'd4, I_LD,  5'd16, RWE | WBS,  "ld_wb");
        // BEQ taken
        step(0, 1, 1, 1, I_BEQ, 3'd0, I_LD,  5'd16, REQ | PCE,       "beq1_f");
        step(0, 1, 1, 1, I_BEQ, 3'd1, I_BEQ, 5'd16, 11'd0,           "beq1_d");
        step(0, 1, 1, 1, I_BEQ, 3'd2, I_BEQ, 5'd1,  AST | PCE | PCS, "beq1_e");
        // BEQ not taken
        step(0, 1, 1, 0, I_BEQ, 3'd0, I_BEQ, 5'd1, REQ | PCE, "beq2_f");
        step(0, 1, 1, 0, I_ST,  3'd1, I_BEQ, 5'd1, 11'd0,     "beq2_d");
        step(0, 1, 1, 0, I_ST,  3'd2, I_BEQ, 5'd1, AST,       "beq2_e");
        // ST with one ALU wait cycle; stray mem_ready in EXECUTE ignored
        step(0, 1, 1, 0, I_ST,  3'd0, I_BEQ, 5'd1,  REQ | PCE,       "st_f");
        step(0, 1, 0, 0, I_BAD, 3'd1, I_ST,  5'd1,  11'd0,           "st_d");
        step(0, 1, 0, 0, I_BAD, 3'd2, I_ST,  5'd16, AST | SIMM,      "st_e0");
        step(0, 1, 1, 0, I_BAD, 3'd2, I_ST,  5'd16, SIMM,            "st_e1");
        step(0, 1, 1, 0, I_BAD, 3'd3, I_ST,  5'd16, REQ | ASEL | WE, "st_m");
        // undefined opcode 12
        step(0, 1, 1, 0, I_BAD, 3'd0, I_ST,  5'd16, REQ | PCE, "bad_f");
        step(0, 1, 1, 0, I_JMP, 3'd1, I_BAD, 5'd16, ILL,       "bad_d");
        // JMP
        step(0, 1, 1, 0, I_JMP, 3'd0, I_BAD, 5'd0, REQ | PCE, "jmp_f");
        step(0, 1, 1, 0, I_HLT, 3'd1, I_JMP, 5'd0, PCE | PCS, "jmp_d");
        // HLT, then stay halted with handshakes active
        step(0, 1, 1, 0, I_HLT, 3'd0, I_JMP, 5'd0, REQ | PCE, "hlt_f");
        step(0, 1, 1, 0, I_HLT, 3'd1, I_HLT, 5'd0, 11'd0,     "hlt_d");
        for (int i = 0; i < 20; i++)
            step(0, 1, 1, 1, I_ART, 3'd5, I_HLT, 5'd0, HLTD, "halt");
        step(1, 1, 1, 0, I_LD, 3'd0, 19'd0, 5'd0, 11'd0, "hlt_rst");
        // LD interrupted by reset during MEM
        step(0, 1, 1, 0, I_LD, 3'd0, 19'd0, 5'd0,  REQ | PCE,  "ld2_f");
        step(0, 1, 1, 0, I_LD, 3'd1, I_LD,  5'd0,  11'd0,      "ld2_d");
        step(0, 0, 1, 0, I_LD, 3'd2, I_LD,  5'd16, AST | SIMM, "ld2_e");
        step(0, 0, 1, 0, I_LD, 3'd3, I_LD,  5'd16, REQ | ASEL, "ld2_m");
        step(1, 1, 1, 0, I_LD, 3'd0, 19'd0, 5'd0,  11'd0,      "ld2_rst");
        step(1, 1, 1, 0, I_LD, 3'd0, 19'd0, 5'd0,  11'd0,      "ld2_rst_hold");
        step(0, 0, 1, 0, I_LD, 3'd0, 19'd0, 5'd0,  REQ,        "ld2_refetch");
        step(0, 0, 1, 0, I_LD, 3'd0, 19'd0, 5'd0,  REQ,        "ld2_refetch2");
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
